// File: rtl/branch_unit.sv
// branch_unit: flag register, program counter and conditional-branch sequencer for IPPro.
// Optional hardware loop counter (condition code 9) is built only when BRANCH_LOOP_EN is defined.
module branch_unit #(
  parameter int PC_WIDTH     = 10,
  parameter int FLUSH_CYCLES = 2,
  parameter int LOOP_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  flag_valid_i,
  input  logic                  zf_i,
  input  logic                  eqf_i,
  input  logic                  gtf_i,
  input  logic                  sf_i,
  input  logic                  br_valid_i,
  input  logic [3:0]            br_cond_i,
  input  logic [PC_WIDTH-1:0]   br_target_i,
  input  logic                  loop_set_i,
  input  logic [LOOP_WIDTH-1:0] loop_count_i,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  br_taken_o,
  output logic                  flush_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_EQ     = 4'd3;
  localparam logic [3:0] COND_NEQ    = 4'd4;
  localparam logic [3:0] COND_GT     = 4'd5;
  localparam logic [3:0] COND_NGT    = 4'd6;
  localparam logic [3:0] COND_S      = 4'd7;
  localparam logic [3:0] COND_NS     = 4'd8;
  localparam logic [3:0] COND_LOOP   = 4'd9;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  // Flags are packed {Z, EQ, GT, S}; loop_ok is only ever set in the loop build.
  function automatic logic cond_eval(input logic [3:0] cond,
                                     input logic [3:0] flg,
                                     input logic       loop_ok);
    logic res;
    res = 1'b0;
    case (cond)
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = flg[3];
      COND_NZ:     res = ~flg[3];
      COND_EQ:     res = flg[2];
      COND_NEQ:    res = ~flg[2];
      COND_GT:     res = flg[1];
      COND_NGT:    res = ~flg[1];
      COND_S:      res = flg[0];
      COND_NS:     res = ~flg[0];
      COND_LOOP:   res = loop_ok;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                br_taken_q, br_taken_d;
  logic                flush_q, flush_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [3:0]          flags_q, flags_d;
  logic [3:0]          flags_in_s;
  logic [3:0]          flags_eff_s;
  logic                loop_ok_s;
  logic                take_s;

  assign flags_in_s  = {zf_i, eqf_i, gtf_i, sf_i};
  // A flag-producing instruction in the same cycle as the branch is forwarded.
  assign flags_eff_s = flag_valid_i ? flags_in_s : flags_q;

`ifdef BRANCH_LOOP_EN
  logic [LOOP_WIDTH-1:0] loop_q, loop_d;

  // A load in the same cycle as a cond-9 branch wins, so that branch falls through.
  assign loop_ok_s = ~loop_set_i & (loop_q != {LOOP_WIDTH{1'b0}});

  // Loop counter next state: load in RUN, decrement on each taken cond-9 branch.
  always_comb begin
    loop_d = loop_q;
    if (enable_i && (state_q == RUN)) begin
      if (loop_set_i) begin
        loop_d = loop_count_i;
      end else if (br_valid_i && (br_cond_i == COND_LOOP) && loop_ok_s) begin
        loop_d = loop_q - LOOP_WIDTH'(1);
      end else begin
        loop_d = loop_q;
      end
    end else begin
      loop_d = loop_q;
    end
  end

  // Loop counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loop_q <= {LOOP_WIDTH{1'b0}};
    end else begin
      loop_q <= loop_d;
    end
  end
`else
  logic                  unused_loop_set_s;
  logic [LOOP_WIDTH-1:0] unused_loop_count_s;

  assign unused_loop_set_s   = loop_set_i;
  assign unused_loop_count_s = loop_count_i;
  assign loop_ok_s           = 1'b0;
`endif

  assign take_s = br_valid_i & cond_eval(br_cond_i, flags_eff_s, loop_ok_s);

  // Sequencer next state: PC advance, branch redirect and squash window.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    br_taken_d = br_taken_q;
    flush_d    = flush_q;
    fcnt_d     = fcnt_q;
    flags_d    = flags_q;

    if (enable_i && flag_valid_i && !flush_q) begin
      flags_d = flags_in_s;
    end else begin
      flags_d = flags_q;
    end

    if (enable_i) begin
      case (state_q)
        RUN: begin
          if (take_s) begin
            pc_d       = br_target_i;
            br_taken_d = 1'b1;
            flush_d    = 1'b1;
            fcnt_d     = CNT_W'(FLUSH_CYCLES - 1);
            state_d    = SQUASH;
          end else begin
            pc_d       = pc_q + PC_WIDTH'(1);
            br_taken_d = 1'b0;
          end
        end
        SQUASH: begin
          pc_d       = pc_q + PC_WIDTH'(1);
          br_taken_d = 1'b0;
          if (fcnt_q == {CNT_W{1'b0}}) begin
            flush_d = 1'b0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d    = RUN;
          flush_d    = 1'b0;
          br_taken_d = 1'b0;
          fcnt_d     = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      pc_q       <= {PC_WIDTH{1'b0}};
      br_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      fcnt_q     <= {CNT_W{1'b0}};
      flags_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_taken_q <= br_taken_d;
      flush_q    <= flush_d;
      fcnt_q     <= fcnt_d;
      flags_q    <= flags_d;
    end
  end

  assign pc_o       = pc_q;
  assign br_taken_o = br_taken_q;
  assign flush_o    = flush_q;

endmodule
